// File: rtl/synth_framer_pkg.sv
// Shared definitions for the synthesis framer: settings offsets, FSM states
// and the configuration record handed from the settings block to the framer.
package synth_framer_pkg;

  localparam int SR_NUM_CHAN = 0;
  localparam int SR_FPP      = 1;
  localparam int SR_MASK     = 2;

  // Config fields are sized for the largest supported build (256 channels);
  // smaller builds zero-extend into them and use only the low bits.
  localparam int CFG_CHAN_W = 8;
  localparam int CFG_MASK_W = 256;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [CFG_CHAN_W-1:0] n_chan_m1;
    logic [15:0]           fpp_m1;
    logic [CFG_MASK_W-1:0] mask;
  } cfg_t;

  // Drop mask bits at or above the programmed channel count.
  function automatic logic [CFG_MASK_W-1:0] eff_mask(input logic [CFG_MASK_W-1:0] m,
                                                      input logic [CFG_CHAN_W-1:0] n_m1);
    logic [CFG_MASK_W-1:0] e;
    e = '0;
    for (int i = 0; i < CFG_MASK_W; i++)
      if (i <= int'(n_m1)) e[i] = m[i];
    return e;
  endfunction

endpackage

// File: rtl/synth_framer_cfg.sv
// Settings-bus decode, live config registers and the packet-boundary shadow copy.
module synth_framer_cfg
  import synth_framer_pkg::*;
#(
  parameter int         MAX_CHAN   = 64,
  parameter logic [7:0] SR_BASE    = 8'd130,
  parameter int         CH_W       = $clog2(MAX_CHAN),
  parameter int         MASK_WORDS = (MAX_CHAN+31)/32
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        load,
  output cfg_t        cfg_sh,
  output logic        live_any,
  output logic        clr_err
);

  logic [CH_W-1:0]          n_chan_m1_r;
  logic [15:0]              fpp_m1_r;
  logic [MASK_WORDS*32-1:0] mask_r;
  cfg_t                     cfg_live;
  logic                     unused_mask;

  // Live registers, written straight from the settings bus.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      n_chan_m1_r <= CH_W'(MAX_CHAN-1);
      fpp_m1_r    <= '0;
      mask_r      <= '1;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_BASE + SR_NUM_CHAN)) n_chan_m1_r <= set_data[CH_W-1:0];
      if (set_addr == 8'(SR_BASE + SR_FPP))      fpp_m1_r    <= set_data[15:0];
      for (int k = 0; k < MASK_WORDS; k++)
        if (set_addr == 8'(SR_BASE + SR_MASK + k)) mask_r[32*k +: 32] <= set_data;
    end
  end

  // Live view with the mask already trimmed to the channel count.
  always_comb begin
    cfg_live           = '0;
    cfg_live.n_chan_m1 = CFG_CHAN_W'(n_chan_m1_r);
    cfg_live.fpp_m1    = fpp_m1_r;
    cfg_live.mask      = eff_mask(CFG_MASK_W'(mask_r[MAX_CHAN-1:0]), cfg_live.n_chan_m1);
  end

  assign live_any    = |cfg_live.mask;
  assign clr_err     = set_stb && (set_addr == 8'(SR_BASE + SR_NUM_CHAN));
  assign unused_mask = ^mask_r;

  // Shadow copy used by the framer; only refreshed while the framer is idle.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) cfg_sh <= '0;
    else if (load) cfg_sh <= cfg_live;
  end

endmodule

// File: rtl/synth_frame_framer.sv
// Expands a compacted enabled-channel stream into full n_chan-slot frames with
// sof/channel sideband and packet tlast. Optional SYNTH_FRAMER_STATS_EN adds
// frame_cnt / err_cnt statistics outputs.
module synth_frame_framer
  import synth_framer_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         MAX_CHAN   = 64,
  parameter logic [7:0] SR_BASE    = 8'd130,
  parameter int         CH_W       = $clog2(MAX_CHAN),
  parameter int         MASK_WORDS = (MAX_CHAN+31)/32
) (
  input  logic             ce_clk,
  input  logic             ce_rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_tsof,
  output logic [CH_W-1:0]  o_tchan,
  output logic             err_misalign
`ifdef SYNTH_FRAMER_STATS_EN
  ,
  output logic [31:0]      frame_cnt,
  output logic [15:0]      err_cnt
`endif
);

  state_t          state, state_nx;
  logic [CH_W-1:0] slot, slot_nx;
  logic [15:0]     frame, frame_nx;
  cfg_t            cfg_sh;
  logic            live_any, clr_err, load;
  logic            adv, take, set_err, go_flush;
  logic [CH_W-1:0]     n_m1;
  logic [MAX_CHAN-1:0] mask_sh;
  logic            out_free, slot_en, last_slot, last_frame, last_en;
  logic            unused_cfg;

  synth_framer_cfg #(
    .MAX_CHAN(MAX_CHAN), .SR_BASE(SR_BASE), .CH_W(CH_W), .MASK_WORDS(MASK_WORDS)
  ) u_cfg (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .load(load), .cfg_sh(cfg_sh), .live_any(live_any), .clr_err(clr_err)
  );

  assign n_m1       = cfg_sh.n_chan_m1[CH_W-1:0];
  assign mask_sh    = cfg_sh.mask[MAX_CHAN-1:0];
  assign unused_cfg = ^cfg_sh;
  assign out_free   = !o_tvalid || o_tready;
  assign slot_en    = mask_sh[slot];
  assign last_slot  = (slot == n_m1);
  assign last_frame = (frame == cfg_sh.fpp_m1);
  // No enabled slot above the current one: this slot should carry i_tlast.
  assign last_en    = ((mask_sh >> slot) >> 1) == '0;

  // State, slot and frame counters.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state <= IDLE;
      slot  <= '0;
      frame <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
      frame <= frame_nx;
    end
  end

  // Next-state, slot advance and input handshake.
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    frame_nx = frame;
    i_tready = 1'b0;
    load     = 1'b0;
    adv      = 1'b0;
    take     = 1'b0;
    set_err  = 1'b0;
    go_flush = 1'b0;
    case (state)
      IDLE: begin
        load     = 1'b1;
        slot_nx  = '0;
        frame_nx = '0;
        if (live_any) state_nx = RUN;
      end
      RUN: begin
        if (slot_en) begin
          i_tready = out_free;
          if (out_free && i_tvalid) begin
            adv  = 1'b1;
            take = 1'b1;
            if (i_tlast && !last_en) begin
              set_err  = 1'b1;
              go_flush = 1'b1;
            end else if (!i_tlast && last_en) begin
              set_err  = 1'b1;
            end
          end
        end else if (out_free) begin
          adv = 1'b1;
        end
      end
      FLUSH: if (out_free) adv = 1'b1;
      default: state_nx = IDLE;
    endcase
    if (adv) begin
      if (last_slot) begin
        slot_nx  = '0;
        frame_nx = frame + 16'd1;
        state_nx = last_frame ? IDLE : RUN;
      end else begin
        slot_nx = slot + CH_W'(1);
        if (go_flush) state_nx = FLUSH;
      end
    end
  end

  // Output register: loads a slot when it advances, holds while stalled.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tsof   <= 1'b0;
      o_tchan  <= '0;
    end else if (adv) begin
      o_tvalid <= 1'b1;
      o_tdata  <= take ? i_tdata : '0;
      o_tlast  <= last_slot && last_frame;
      o_tsof   <= (slot == '0);
      o_tchan  <= slot;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Sticky misalignment flag; a channel-count write clears it.
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n)    err_misalign <= 1'b0;
    else if (set_err) err_misalign <= 1'b1;
    else if (clr_err) err_misalign <= 1'b0;
  end

`ifdef SYNTH_FRAMER_STATS_EN
  // Completed-frame counter (wraps) and misalignment counter (saturates).
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (adv && last_slot) frame_cnt <= frame_cnt + 32'd1;
      if (set_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_synth_frame_framer.sv
// Directed + randomized bench for synth_frame_framer with a frame-level reference model.
module tb_synth_frame_framer;

  localparam int         WIDTH    = 32;
  localparam int         MAX_CHAN = 64;
  localparam int         CH_W     = 6;
  localparam logic [7:0] SR_BASE  = 8'd130;

  typedef struct packed {
    logic [31:0]     data;
    logic            last;
    logic            sof;
    logic [CH_W-1:0] chan;
  } beat_t;
  typedef struct packed { logic [31:0] data; logic last; } samp_t;
  typedef struct { int trig; logic [7:0] addr; logic [31:0] data; } wr_t;

  logic             ce_clk = 0, ce_rst_n = 0;
  logic             set_stb = 0;
  logic [7:0]       set_addr = 0;
  logic [31:0]      set_data = 0;
  logic [WIDTH-1:0] i_tdata = 0;
  logic             i_tlast = 0, i_tvalid = 0, o_tready = 0;
  logic             i_tready, o_tlast, o_tvalid, o_tsof, err_misalign;
  logic [WIDTH-1:0] o_tdata;
  logic [CH_W-1:0]  o_tchan;
`ifdef SYNTH_FRAMER_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  samp_t in_q[$];
  beat_t exp_q[$], got_q[$];
  wr_t   wr_q[$];
  bit    exp_err;
  int    errors = 0, checks = 0;

  synth_frame_framer #(.WIDTH(WIDTH), .MAX_CHAN(MAX_CHAN), .SR_BASE(SR_BASE)) dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tsof(o_tsof), .o_tchan(o_tchan), .err_misalign(err_misalign)
`ifdef SYNTH_FRAMER_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 ce_clk = ~ce_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    @(negedge ce_clk);
    set_stb = 1; set_addr = 8'(SR_BASE + off); set_data = d;
    @(posedge ce_clk); #1;
    set_stb = 0;
  endtask

  task automatic prog(input int nch, input logic [63:0] mask, input int fpp);
    wr(0, nch - 1);
    wr(1, fpp - 1);
    wr(3, mask[63:32]);
    wr(2, mask[31:0]);
  endtask

  // Queue a mask-clear so the DUT parks in IDLE once the current last packet ends.
  task automatic park();
    wr_t w;
    w.trig = exp_q.size() - 3; w.addr = 8'(SR_BASE + 2); w.data = 0; wr_q.push_back(w);
    w.addr = 8'(SR_BASE + 3); wr_q.push_back(w);
  endtask

  // Build an input stream: per frame, one sample per enabled slot, tlast on the last one.
  task automatic gen_in(input int nch, input logic [63:0] mask, input int frames);
    int hi;
    samp_t s;
    hi = 0;
    for (int c = 0; c < nch; c++) if (mask[c]) hi = c;
    for (int f = 0; f < frames; f++)
      for (int c = 0; c < nch; c++)
        if (mask[c]) begin
          s.data = $urandom; s.last = (c == hi); in_q.push_back(s);
        end
  endtask

  // Reference: walk packets/frames/slots from the framing rules.
  task automatic model(input int nch, input logic [63:0] mask, input int fpp, input int npk);
    samp_t q[$];
    q = in_q;
    exp_q.delete();
    exp_err = 0;
    for (int p = 0; p < npk; p++)
      for (int f = 0; f < fpp; f++) begin
        bit flush;
        flush = 0;
        for (int s = 0; s < nch; s++) begin
          beat_t b;
          b.sof  = (s == 0);
          b.chan = CH_W'(s);
          b.last = (f == fpp - 1) && (s == nch - 1);
          b.data = 0;
          if (!flush && mask[s]) begin
            samp_t x;
            bit later;
            x = q.pop_front();
            b.data = x.data;
            later = 0;
            for (int t = s + 1; t < nch; t++) later |= mask[t];
            if (x.last && later) begin flush = 1; exp_err = 1; end
            else if (!x.last && !later) exp_err = 1;
          end
          exp_q.push_back(b);
        end
      end
  endtask

  // Drive in_q / sink output with a ready pattern (0 always, 1 toggle, 2 random); compare.
  task automatic run(input string tag, input int mode);
    beat_t cur, held;
    bit    stalled, fire_in;
    int    cyc;
    stalled = 0;
    for (cyc = 0; cyc < 4000 && got_q.size() < exp_q.size(); cyc++) begin
      @(negedge ce_clk);
      set_stb = 0;
      if (wr_q.size() > 0 && got_q.size() >= wr_q[0].trig) begin
        set_stb = 1; set_addr = wr_q[0].addr; set_data = wr_q[0].data;
        void'(wr_q.pop_front());
      end
      o_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
      i_tvalid = in_q.size() > 0;
      if (i_tvalid) begin i_tdata = in_q[0].data; i_tlast = in_q[0].last; end
      #1;
      cur.data = o_tdata; cur.last = o_tlast; cur.sof = o_tsof; cur.chan = o_tchan;
      if (stalled) chk({tag, "_hold"}, {o_tvalid, cur}, {1'b1, held});
      stalled = o_tvalid && !o_tready;
      held    = cur;
      if (o_tvalid && o_tready) got_q.push_back(cur);
      fire_in = i_tvalid && i_tready;
      @(posedge ce_clk);
      if (fire_in) void'(in_q.pop_front());
    end
    while (wr_q.size() > 0) begin
      @(negedge ce_clk);
      set_stb = 1; set_addr = wr_q[0].addr; set_data = wr_q[0].data;
      void'(wr_q.pop_front());
    end
    @(negedge ce_clk);
    set_stb = 0; i_tvalid = 0; o_tready = 1;
    chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_in_left"}, in_q.size(), 0);
    got_q.delete();
    in_q.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_vld"}, o_tvalid, 0);
    chk({tag, "_data"}, o_tdata, 0);
    chk({tag, "_side"}, {o_tlast, o_tsof, o_tchan}, 0);
    chk({tag, "_rdy"}, i_tready, 0);
    chk({tag, "_err"}, err_misalign, 0);
  endtask

  task automatic scen1(input string tag);
    samp_t s;
    for (int i = 0; i < 64; i++) begin
      s.data = 32'h100 + i; s.last = (i == 63); in_q.push_back(s);
    end
    model(64, '1, 1, 1);
    park();
    run(tag, 0);
    chk({tag, "_err"}, err_misalign, 0);
  endtask

  initial begin
    samp_t s;
    int nch, fpp;
    logic [63:0] m;

    // Reset state
    #23;
    check_reset_outs("rst");
    @(negedge ce_clk); ce_rst_n = 1;

    // 1: defaults
    scen1("s1");

    // 2: 4 channels, mask 1010, 2 frames/packet
    s.data = 32'hA; s.last = 0; in_q.push_back(s);
    s.data = 32'hB; s.last = 1; in_q.push_back(s);
    s.data = 32'hC; s.last = 0; in_q.push_back(s);
    s.data = 32'hD; s.last = 1; in_q.push_back(s);
    model(4, 64'hA, 2, 1);
    prog(4, 64'hA, 2);
    park();
    run("s2", 0);

    // 3: same, ready toggling
    s.data = 32'hA; s.last = 0; in_q.push_back(s);
    s.data = 32'hB; s.last = 1; in_q.push_back(s);
    s.data = 32'hC; s.last = 0; in_q.push_back(s);
    s.data = 32'hD; s.last = 1; in_q.push_back(s);
    model(4, 64'hA, 2, 1);
    prog(4, 64'hA, 2);
    park();
    run("s3", 1);

    // 4: early tlast -> flush, then clear via channel-count write
    for (int i = 0; i < 6; i++) begin
      s.data = 32'h200 + i; s.last = (i == 1) || (i == 5); in_q.push_back(s);
    end
    model(4, 64'hF, 1, 2);
    chk("s4_model_err", exp_err, 1'b1);
    prog(4, 64'hF, 1);
    park();
    run("s4", 2);
    chk("s4_err", err_misalign, 1);
    wr(0, 3);
    chk("s4_clr", err_misalign, 0);

    // 4b: missing tlast on last enabled slot
    for (int i = 0; i < 8; i++) begin
      s.data = 32'h300 + i; s.last = (i == 7); in_q.push_back(s);
    end
    model(4, 64'hF, 1, 2);
    prog(4, 64'hF, 1);
    park();
    run("s4b", 0);
    chk("s4b_err", err_misalign, 1);
    wr(0, 3);
    chk("s4b_clr", err_misalign, 0);

    // single channel: sof on every beat
    gen_in(1, 64'h1, 4);
    model(1, 64'h1, 4, 1);
    prog(1, 64'h1, 4);
    park();
    run("s1ch", 2);

    // randomized configs
    for (int r = 0; r < 5; r++) begin
      nch = $urandom_range(2, 8);
      fpp = $urandom_range(2, 3);
      m   = 64'($urandom_range(1, (1 << nch) - 1));
      gen_in(nch, m, 2 * fpp);
      model(nch, m, fpp, 2);
      prog(nch, m, fpp);
      park();
      run($sformatf("rnd%0d", r), 2);
      chk($sformatf("rnd%0d_err", r), err_misalign, 0);
    end

    // 5: mask cleared mid-packet -> packet finishes, then idle forever
    gen_in(4, 64'hF, 2);
    model(4, 64'hF, 2, 1);
    prog(4, 64'hF, 2);
    wr_q.push_back('{trig: 1, addr: 8'(SR_BASE + 2), data: 32'h0});
    run("s5", 2);
    for (int i = 0; i < 30; i++) begin
      @(negedge ce_clk);
      i_tvalid = 1; i_tdata = $urandom; i_tlast = 0; o_tready = 1;
      #1;
      chk($sformatf("s5_idle%0d", i), {i_tready, o_tvalid}, 2'b00);
    end
    i_tvalid = 0;

    // 6: reset mid-frame, then defaults again
    @(negedge ce_clk); ce_rst_n = 0;
    @(negedge ce_clk); ce_rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ce_clk);
      i_tvalid = 1; i_tdata = 32'h500 + i; i_tlast = 0; o_tready = 1;
    end
    #1;
    chk("s6_pre_vld", o_tvalid, 1);
    @(posedge ce_clk); #3;
    ce_rst_n = 0;
    #1;
    check_reset_outs("s6_rst");
    i_tvalid = 0;
    @(negedge ce_clk); ce_rst_n = 1;
    scen1("s6_s1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/synth_frame_framer.md
Name: synth_frame_framer

Overview:
- Parametrised framing stage that sits between the AXI wrapper's m_axis data port and the synthesis filterbank core in a synthesis RFNoC block.
- Input is a compacted stream holding only the enabled channels' samples, in ascending channel order, one frame after another.
- Output is full frames of n_chan slots, with zeros in disabled slots, plus start-of-frame and channel-index sideband and packetised tlast.
- Number of channels, channel mask and frames-per-packet are programmed at runtime over the settings bus. This generalises the fixed-channel synthesis front end.

Parameters:
- WIDTH, 32, sample width (packed IQ).
- MAX_CHAN, 64, maximum channel count; power of two, 2..256.
- SR_BASE, 8'd130, first settings-register address.
- CH_W, $clog2(MAX_CHAN), channel index width (derived).
- MASK_WORDS, (MAX_CHAN+31)/32, number of mask registers (derived).

Ports:
- ce_clk  in  1  clock
- ce_rst_n  in  1  asynchronous active-low reset
- set_stb  in  1  settings strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- i_tdata  in  WIDTH  compacted input samples
- i_tlast  in  1  marks last enabled sample of an input frame (alignment check only)
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  WIDTH  framed output sample
- o_tlast  out  1  last slot of the last frame of a packet
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready
- o_tsof  out  1  high on slot 0 of each frame
- o_tchan  out  CH_W  slot channel index
- err_misalign  out  1  sticky misalignment flag

Behaviour:
- Clock and reset:
  - Single clock, ce_clk.
  - ce_rst_n is asynchronous and active-low; it clears all state and registers immediately.
  - Reset values: o_tvalid=0, o_tdata=0, o_tlast=0, o_tsof=0, o_tchan=0, i_tready=0, err_misalign=0, state IDLE.
- Settings registers:
  - SR_BASE+0: n_chan_m1[CH_W-1:0]; channels = value+1. Reset value is MAX_CHAN-1. Any write here also clears err_misalign.
  - SR_BASE+1: fpp_m1[15:0]; frames per packet = value+1. Reset value is 0.
  - SR_BASE+2+k, k<MASK_WORDS: mask bits [32k+31:32k]. Reset value is all ones.
  - Mask bits at index ≥ channels are ignored.
- Shadow config:
  - Live registers are copied to shadow registers only in IDLE, i.e. at packet boundaries.
  - A mid-packet write therefore takes effect on the next packet.
- FSM, IDLE:
  - Load the shadow config and reset the slot and frame counters.
  - If the effective mask is nonzero, go to RUN. Otherwise stay in IDLE with i_tready=0 and nothing emitted.
- FSM, RUN:
  - Slot counter walks 0..channels-1.
  - Enabled slot: the output takes i_tdata; i_tready = output register free or draining.
  - Disabled slot: emit zero without consuming input; i_tready=0.
  - At the last slot, the frame counter increments.
  - At the last slot of frame fpp_m1: o_tlast=1, then return to IDLE.
- FSM, FLUSH:
  - Entered when i_tlast is accepted on an enabled slot that is not the last enabled slot of the frame. Set err_misalign.
  - Emit zeros for the remaining slots without consuming input, then continue as at a normal frame end.
  - Missing i_tlast on the last enabled slot is also an error: set err_misalign, no flush; the next input sample is treated as slot-0 data.
- Output stage:
  - Registered, latency 1 cycle from input acceptance to o_tvalid.
  - Throughput is 1 slot per cycle while o_tready=1.
  - o_tdata, o_tlast, o_tsof and o_tchan are held stable while o_tvalid && !o_tready.
- Single-channel case: channels=1 gives o_tsof=1 on every beat.
- Slot counter wrap: exactly at channels-1; never reaches MAX_CHAN in the non-power-of-two case.

Optional Feature:
- Macro: SYNTH_FRAMER_STATS_EN.
- With it defined:
  - Extra output frame_cnt[31:0], incremented per completed output frame and wrapping at 2^32.
  - Extra output err_cnt[15:0], incremented per misalignment event and saturating at 16'hFFFF.
  - Both reset to 0 on ce_rst_n.
- Without it: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package synth_framer_pkg holds:
  - SR offset constants (SR_NUM_CHAN=0, SR_FPP=1, SR_MASK=2);
  - the FSM state enum (IDLE/RUN/FLUSH);
  - the cfg_t struct (n_chan_m1, fpp_m1, mask).
- Sub-module synth_framer_cfg: settings decode, live registers and shadow load. The top module holds the FSM, counters and output register.

Test Plan:
1. Defaults (64 channels, full mask, fpp=1), input 0x100..0x13F with i_tlast on 0x13F -> 64 beats 0x100..0x13F, o_tsof on beat 0, o_tlast on beat 63, err_misalign=0.
2. n_chan_m1=3, mask=4'b1010, fpp_m1=1, input A,B,C,D with i_tlast on B and D -> 0,A,0,B,0,C,0,D; o_tchan 0,1,2,3,0,1,2,3; o_tlast only on D.
3. Same config as 2, o_tready toggled 1010… -> no duplicated or dropped beats, outputs held stable while stalled.
4. n_chan_m1=3, full mask, i_tlast on the 2nd sample -> err_misalign=1, two zero slots flushed, next sample lands in slot 0. A write to SR_BASE+0 then clears err_misalign.
5. Write mask=0 in mid-packet -> current packet completes with the old mask; afterwards i_tready=0 and o_tvalid=0 indefinitely.
6. Drop ce_rst_n mid-frame -> all outputs return to reset values immediately; after release the defaults are restored and scenario 1 passes.
